cog_frame_controller: RTL
=========================

// Module: cog_frame_controller
// PURPOSE
//  Frame-level sequencer in front of the CoG pipeline input. Gates the video AXI-Stream
//  on frame boundaries (continuous / single-shot / abort) and checks frame geometry
//  (WIDTH x HEIGHT). Zero-latency pass-through; the CoG top input connects to m_axis_*.
// PARAMETERS
//  DATA_WIDTH  8     bits per colour component; tdata = 3*DATA_WIDTH
//  WIDTH       1280  pixels per line
//  HEIGHT      1024  lines per frame
// PORTS
//  i_sys_clk        in   1              single clock
//  i_sys_aresetn    in   1              asynchronous active-low reset
//  i_run            in   1              level: capture frames continuously
//  i_single_shot    in   1              pulse: capture exactly one frame
//  i_abort          in   1              pulse: stop immediately, discard rest of frame
//  s_axis_tdata     in   3*DATA_WIDTH   video in; tuser = SOF, tlast = EOL
//  s_axis_tvalid / s_axis_tuser / s_axis_tlast  in  1 each
//  s_axis_tready    out  1
//  m_axis_tdata     out  3*DATA_WIDTH   to CoG pipeline
//  m_axis_tvalid / m_axis_tuser / m_axis_tlast  out 1 each
//  m_axis_tready    in   1              from CoG pipeline
//  o_busy           out  1              state is ARMED, ACTIVE or DRAIN
//  o_frame_done     out  1              1-cycle pulse: complete frame forwarded
//  o_err_geom       out  1              1-cycle pulse: line length or frame height error
//  o_frames_ok      out  16             frames completed (saturating)
//  o_frames_err     out  16             geometry errors + aborts (saturating)
// BEHAVIOUR
//  Beat = s_axis_tvalid & s_axis_tready. Reset: state IDLE; all outputs 0; counters 0.
//  States: IDLE, ARMED, ACTIVE, DRAIN.
//   IDLE  : s_axis_tready=1, beats discarded. i_run|i_single_shot -> ARMED; latch one_shot.
//   ARMED : discard until beat with tuser=1; that beat forwarded, -> ACTIVE.
//   ACTIVE: m_axis_t* = s_axis_t*, m_axis_tvalid = s_axis_tvalid,
//           s_axis_tready = m_axis_tready (combinational, no stall buffering).
//           col counts 0..WIDTH-1, line 0..HEIGHT-1, advanced on accepted beats only.
//   DRAIN : s_axis_tready=1, discard until beat with tuser=1 (not forwarded) -> IDLE.
//  Frame end: accepted beat with tlast & col==WIDTH-1 & line==HEIGHT-1 -> o_frame_done,
//   o_frames_ok++; -> ARMED if i_run & !one_shot, else IDLE (one_shot cleared).
//  Geometry errors (ACTIVE, accepted beat) -> o_err_geom pulse, o_frames_err++:
//   tlast with col!=WIDTH-1, or col==WIDTH-1 without tlast: short/long line; col resets
//    to 0 on tlast; a missing tlast wraps col to 0 and advances line.
//   tuser with (line,col)!=(0,0): premature SOF; beat forwarded as new frame, counters
//    restart at (0,1), state stays ACTIVE.
//  i_abort in ARMED -> IDLE; in ACTIVE -> DRAIN, o_frames_err++ (beat that cycle still
//   forwarded if handshaken). Abort wins over frame end in the same cycle.
//  i_run deassert mid-frame: frame finishes normally (graceful stop), then IDLE.
//  i_single_shot while busy: ignored. Counters saturate at 16'hFFFF.
//  Reset mid-frame: immediate IDLE, m_axis_tvalid=0; downstream sees truncated frame.
// CONFIGURATION
//  `COG_FRAME_STATS_EN defined: o_frames_ok / o_frames_err counters implemented.
//  Not defined: both outputs tied to 16'd0, counter flops removed; pulses unaffected.
// STRUCTURE
//  cog_pkg: typedef enum logic [1:0] cog_frame_state_t {IDLE,ARMED,ACTIVE,DRAIN};
//   localparams COG_STAT_W=16; column/line widths via $clog2(WIDTH)/$clog2(HEIGHT).
//  Sub-module cog_frame_geom_checker: col/line counters, frame_end and error pulses.
// TESTING (WIDTH=8, HEIGHT=4 for sim)
//  1 i_run=1, 3 clean frames -> 3 o_frame_done pulses, o_frames_ok=3, all 96 beats out.
//  2 single-shot pulse, 2 frames sent -> only frame 1 forwarded, then IDLE, o_busy=0.
//  3 line 1 tlast at col 5 -> o_err_geom pulse on that beat, o_frames_err=1, no done.
//  4 i_abort at line 2 col 3 -> m_axis_tvalid=0 until next SOF, that SOF discarded, IDLE.
//  5 random m_axis_tready backpressure (50%) -> output beat sequence equals input, no loss.
//  6 tuser at line 2 -> o_err_geom, frame restarts; next full frame gives o_frame_done.

Source files
------------

// File: rtl/cog_pkg.sv
// Shared types and helpers for the CoG frame controller: state encoding, statistic
// counter width and a counter-width helper that stays legal for dimensions of 1.
package cog_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        ACTIVE,
        DRAIN
    } cog_frame_state_t;

    localparam int COG_STAT_W = 16;

    function automatic int cog_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cog_frame_geom_checker.sv
// Column/line tracker for one video frame: flags line-length and premature-SOF errors
// and reports the positional end of frame plus whether that frame was error free.
module cog_frame_geom_checker
    import cog_pkg::*;
#(
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,      // frame-opening SOF beat accepted while armed
    input  logic beat_i,       // beat accepted while a frame is active
    input  logic tuser_i,
    input  logic tlast_i,
    output logic frame_end_o,
    output logic done_o,
    output logic err_o
);

    localparam int COL_W  = cog_cnt_w(WIDTH);
    localparam int LINE_W = cog_cnt_w(HEIGHT);

    logic [COL_W-1:0]  col_q, col_d, eff_col;
    logic [LINE_W-1:0] line_q, line_d, eff_line;
    logic              bad_q, bad_d;
    logic              sof_err, restart, any_beat, at_eol, at_last_line, line_err;

    // A restart (fresh or premature SOF) evaluates the beat as position (0,0).
    assign sof_err      = beat_i && tuser_i && ((col_q != '0) || (line_q != '0));
    assign restart      = start_i || sof_err;
    assign any_beat     = beat_i || start_i;
    assign eff_col      = restart ? '0 : col_q;
    assign eff_line     = restart ? '0 : line_q;
    assign at_eol       = (eff_col == COL_W'(WIDTH - 1));
    assign at_last_line = (eff_line == LINE_W'(HEIGHT - 1));
    assign line_err     = any_beat && (tlast_i != at_eol);

    assign frame_end_o  = beat_i && !sof_err && tlast_i && at_eol && at_last_line;
    // A frame that already raised a geometry error still ends, but is not reported as done.
    assign done_o       = frame_end_o && !bad_q;
    assign err_o        = sof_err || line_err;

    always_comb begin
        col_d  = col_q;
        line_d = line_q;
        bad_d  = bad_q;
        if (any_beat) begin
            if (tlast_i || at_eol) begin
                col_d  = '0;
                line_d = at_last_line ? '0 : eff_line + 1'b1;
            end else begin
                col_d  = eff_col + 1'b1;
                line_d = eff_line;
            end
            if (restart) begin
                bad_d = line_err;
            end else if (frame_end_o) begin
                bad_d = 1'b0;
            end else if (line_err) begin
                bad_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q  <= '0;
            line_q <= '0;
            bad_q  <= 1'b0;
        end else begin
            col_q  <= col_d;
            line_q <= line_d;
            bad_q  <= bad_d;
        end
    end

endmodule

// File: rtl/cog_frame_controller.sv
// Frame-boundary gate and geometry checker in front of the CoG pipeline (zero latency).
// Define COG_FRAME_STATS_EN to implement the o_frames_ok / o_frames_err counters.
module cog_frame_controller
    import cog_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 1024
) (
    input  logic                    i_sys_clk,
    input  logic                    i_sys_aresetn,
    input  logic                    i_run,
    input  logic                    i_single_shot,
    input  logic                    i_abort,
    input  logic [3*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tuser,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [3*DATA_WIDTH-1:0] m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tuser,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic                    o_busy,
    output logic                    o_frame_done,
    output logic                    o_err_geom,
    output logic [COG_STAT_W-1:0]   o_frames_ok,
    output logic [COG_STAT_W-1:0]   o_frames_err
);

    cog_frame_state_t state_q, state_d;
    logic             one_shot_q, one_shot_d;
    logic             sof_start, act_beat, frame_end;

    assign m_axis_tdata = s_axis_tdata;
    assign m_axis_tuser = s_axis_tuser;
    assign m_axis_tlast = s_axis_tlast;
    assign o_busy       = (state_q != IDLE);

    // Abort suppresses frame bookkeeping for the beat that is still forwarded.
    assign sof_start = (state_q == ARMED) && s_axis_tvalid && s_axis_tuser
                       && m_axis_tready && !i_abort;
    assign act_beat  = (state_q == ACTIVE) && s_axis_tvalid && m_axis_tready && !i_abort;

    cog_frame_geom_checker #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_geom (
        .clk_i       (i_sys_clk),
        .rst_ni      (i_sys_aresetn),
        .start_i     (sof_start),
        .beat_i      (act_beat),
        .tuser_i     (s_axis_tuser),
        .tlast_i     (s_axis_tlast),
        .frame_end_o (frame_end),
        .done_o      (o_frame_done),
        .err_o       (o_err_geom)
    );

    always_comb begin
        state_d       = state_q;
        one_shot_d    = one_shot_q;
        s_axis_tready = 1'b1;
        m_axis_tvalid = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_run || i_single_shot) begin
                    state_d    = ARMED;
                    one_shot_d = i_single_shot;
                end
            end
            ARMED: begin
                if (i_abort) begin
                    state_d = IDLE;
                end else if (s_axis_tuser) begin
                    s_axis_tready = m_axis_tready;
                    m_axis_tvalid = s_axis_tvalid;
                    if (sof_start) state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
                if (i_abort) begin
                    state_d = DRAIN;
                end else if (frame_end) begin
                    state_d    = (i_run && !one_shot_q) ? ARMED : IDLE;
                    one_shot_d = 1'b0;
                end
            end
            DRAIN: begin
                if (s_axis_tvalid && s_axis_tuser) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) begin
            state_q    <= IDLE;
            one_shot_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            one_shot_q <= one_shot_d;
        end
    end

`ifdef COG_FRAME_STATS_EN
    logic [COG_STAT_W-1:0] frames_ok_q, frames_err_q;
    logic                  abort_err;

    assign abort_err = (state_q == ACTIVE) && i_abort;

    always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
        if (!i_sys_aresetn) begin
            frames_ok_q  <= '0;
            frames_err_q <= '0;
        end else begin
            if (o_frame_done && (frames_ok_q != '1))
                frames_ok_q <= frames_ok_q + 1'b1;
            if ((o_err_geom || abort_err) && (frames_err_q != '1))
                frames_err_q <= frames_err_q + 1'b1;
        end
    end

    assign o_frames_ok  = frames_ok_q;
    assign o_frames_err = frames_err_q;
`else
    assign o_frames_ok  = '0;
    assign o_frames_err = '0;
`endif

endmodule
